stack_exec: RTL and testbench
=============================

# stack_exec

Stack-machine execution sequencer that sits between the instruction decoder and the 16×16 operand stack. It accepts one opcode at a time over a valid/ready handshake and drives the stack's `push`/`pop`/`din`. It consumes the stack's registered `dout` and `tos`, computes ALU results, and pushes them back. It checks underflow and overflow before touching the stack and reports completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 16: data width; must equal the stack width.
- `DEPTH`, default 16: stack depth; used for the overflow check.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset. Shared with the stack.
- `op_valid` in 1: opcode offered.
- `op_ready` out 1: high only in IDLE.
- `op_code` in 4: opcode.
- `op_imm` in WIDTH: immediate for PUSHI.
- `stk_push` out 1: to stack `push`.
- `stk_pop` out 1: to stack `pop`.
- `stk_din` out WIDTH: to stack `din`.
- `stk_dout` in WIDTH: from stack `dout`. Valid the cycle after a pop.
- `stk_tos` in 16: from stack `tos`, the current element count.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; the operation was rejected and the stack is untouched.
- `result` out WIDTH: value pushed, or value popped for POP. Held until the next `done`.

## Operation
- Opcodes:
  - 0 NOP
  - 1 PUSHI: push `op_imm`.
  - 2 POP
  - 3 ADD
  - 4 SUB
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 NOT
  - 9 DUP
  - A MUL: see Configuration.
  - B–F: illegal.
- Operand naming: A is the first value popped (top); B is the second. SUB = B − A.
- All arithmetic is modulo 2^WIDTH. No carry or overflow flags.
- Acceptance: `op_valid && op_ready` is sampled at a rising edge. Opcode and immediate are latched at that edge.
- Legality check at acceptance, using `stk_tos`:
  - POP and NOT need tos ≥ 1.
  - Binary ops need tos ≥ 2.
  - PUSHI needs tos < DEPTH.
  - DUP needs 1 ≤ tos ≤ DEPTH−1.
  - Illegal opcode: always rejected.
- On a failed check: go directly to DONE with `err`=1. No `stk_push` or `stk_pop` is issued, and `result` is unchanged.
- FSM states: IDLE, POP_A, POP_B, CAP_A, CAP_B, PUSH_R, PUSH_R2, DONE.
- State paths after acceptance:
  - NOP / rejected: DONE.
  - PUSHI: PUSH_R, DONE.
  - POP: POP_A, CAP_A, DONE.
  - Binary: POP_A, POP_B, CAP_B, PUSH_R, DONE.
  - NOT: POP_A, CAP_A, PUSH_R, DONE.
  - DUP: POP_A, CAP_A, PUSH_R, PUSH_R2, DONE.
- Per-state actions:
  - `stk_pop`=1 in POP_A and POP_B.
  - POP_B latches A←`stk_dout`.
  - CAP_A latches A←`stk_dout`.
  - CAP_B latches B←`stk_dout`.
  - `stk_push`=1 in PUSH_R and PUSH_R2. `stk_din` holds the result for the whole cycle, and `result` latches it.
- DONE always returns to IDLE.
- `stk_push` and `stk_pop` are never high together.

## Timing
- Reset values:
  - state: IDLE
  - `done`, `err`, `stk_push`, `stk_pop`: 0
  - `result`, A, B, `stk_din`: 0
- `op_ready` is 1 in the first cycle after `rst` deasserts. No opcode is accepted while `rst`=1.
- Control outputs are decoded from the registered state, so there is no combinational path from `op_valid` to stack controls.
- Latency from the acceptance edge to the `done` cycle:
  - NOP / reject: 1
  - PUSHI: 2
  - POP: 3
  - NOT: 4
  - Binary: 5
  - DUP: 5
- Throughput: the next opcode is accepted at the edge ending DONE+1, i.e. in IDLE.
- `stk_dout` is sampled exactly one cycle after its pop. The sequencer never relies on `dout` holding across more than one non-pop cycle.
- Reset mid-operation: the next state is IDLE, A and B are cleared, and no push or pop is issued in the following cycle. The stack resets simultaneously, so no partial result is retained.

## Configuration
- `STACK_EXEC_MUL_EN` defined: opcode A = MUL, result = low WIDTH bits of B×A, same path and latency as binary ops.
- `STACK_EXEC_MUL_EN` undefined: opcode A is illegal and rejected with `err`. No multiplier is synthesized.

## Test plan
- Reset, PUSHI 5, PUSHI 3, SUB → `done` 5 cycles after SUB is accepted, `result`=2, `err`=0, `stk_tos`=1.
- POP with the stack empty → `done`+`err` one cycle after acceptance, `stk_pop` never asserted, `stk_tos` stays 0.
- 16× PUSHI, then a 17th PUSHI 0xAAAA → 17th gets `err`=1, `stk_tos` stays 16. Then 16× POP returns 15..0 in LIFO order.
- PUSHI 0xFFFF, DUP, ADD → DUP `done` at +5 with `stk_tos`=2; ADD `result`=0xFFFE (wrap), `stk_tos`=1.
- PUSHI 0x0012, PUSHI 0x0034, MUL:
  - With `STACK_EXEC_MUL_EN`: `result`=0x03A8.
  - Without it: `err`=1 and `stk_tos` stays 2.
- ADD accepted with 2 elements, `rst` asserted during CAP_B → next cycle IDLE, `op_ready`=1, no `stk_push`, `done`=0, `stk_tos`=0.

Source files
------------

// File: rtl/stack_exec.sv
// Stack-machine execution sequencer: takes one opcode at a time, drives push/pop on the operand stack.
// Optional MUL (opcode A) is enabled by defining STACK_EXEC_MUL_EN.
module stack_exec #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] op_imm,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic [15:0]      stk_tos,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] POP_A   = 3'd1;
  localparam logic [2:0] POP_B   = 3'd2;
  localparam logic [2:0] CAP_A   = 3'd3;
  localparam logic [2:0] CAP_B   = 3'd4;
  localparam logic [2:0] PUSH_R  = 3'd5;
  localparam logic [2:0] PUSH_R2 = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  localparam logic [3:0] OP_NOP = 4'h0, OP_PUSHI = 4'h1, OP_POP = 4'h2, OP_ADD = 4'h3,
                         OP_SUB = 4'h4, OP_AND   = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
                         OP_NOT = 4'h8, OP_DUP   = 4'h9, OP_MUL = 4'hA;

  localparam logic [15:0] DEPTH_T = 16'(DEPTH);

  logic [2:0]       state, nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] imm_q, a, b, alu;
  logic             rej, legal, acc, is_bin;

  assign op_ready = (state == IDLE);
  assign acc      = op_valid && op_ready;
  assign done     = (state == DONE);
  assign err      = done && rej;
  assign stk_pop  = (state == POP_A) || (state == POP_B);
  assign stk_push = (state == PUSH_R) || (state == PUSH_R2);
  assign stk_din  = stk_push ? alu : '0;

  // Only legal opcodes ever leave IDLE, so op_q needs no further qualification here.
  always_comb begin
    is_bin = (op_q >= OP_ADD) && (op_q <= OP_XOR);
`ifdef STACK_EXEC_MUL_EN
    if (op_q == OP_MUL) is_bin = 1'b1;
`endif
  end

  always_comb begin
    legal = 1'b0;
    case (op_code)
      OP_NOP:                                 legal = 1'b1;
      OP_PUSHI:                               legal = stk_tos < DEPTH_T;
      OP_POP, OP_NOT:                         legal = stk_tos >= 16'd1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:  legal = stk_tos >= 16'd2;
      OP_DUP:                                 legal = (stk_tos >= 16'd1) && (stk_tos <= DEPTH_T - 16'd1);
`ifdef STACK_EXEC_MUL_EN
      OP_MUL:                                 legal = stk_tos >= 16'd2;
`endif
      default:                                legal = 1'b0;
    endcase
  end

  // Operands are registered before PUSH_R, so the ALU sees stable inputs for the whole push cycle.
  always_comb begin
    alu = '0;
    case (op_q)
      OP_PUSHI: alu = imm_q;
      OP_ADD:   alu = b + a;
      OP_SUB:   alu = b - a;
      OP_AND:   alu = b & a;
      OP_OR:    alu = b | a;
      OP_XOR:   alu = b ^ a;
      OP_NOT:   alu = ~a;
      OP_DUP:   alu = a;
`ifdef STACK_EXEC_MUL_EN
      OP_MUL:   alu = b * a;
`endif
      default:  alu = '0;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (acc) begin
        if (!legal)                  nxt = DONE;
        else if (op_code == OP_NOP)  nxt = DONE;
        else if (op_code == OP_PUSHI) nxt = PUSH_R;
        else                         nxt = POP_A;
      end
      POP_A:   nxt = is_bin ? POP_B : CAP_A;
      POP_B:   nxt = CAP_B;
      CAP_A:   nxt = (op_q == OP_POP) ? DONE : PUSH_R;
      CAP_B:   nxt = PUSH_R;
      PUSH_R:  nxt = (op_q == OP_DUP) ? PUSH_R2 : DONE;
      PUSH_R2: nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      imm_q  <= '0;
      a      <= '0;
      b      <= '0;
      rej    <= 1'b0;
      result <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        op_q  <= op_code;
        imm_q <= op_imm;
        rej   <= !legal;
      end
      case (state)
        POP_B: a <= stk_dout;
        CAP_A: begin
          a <= stk_dout;
          if (op_q == OP_POP) result <= stk_dout;
        end
        CAP_B:           b <= stk_dout;
        PUSH_R, PUSH_R2: result <= stk_din;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_exec.sv
// Directed bench for stack_exec with a behavioural 16x16 stack (registered dout/tos).
module tb_stack_exec;
  logic        clk = 1'b0, rst = 1'b1, op_valid = 1'b0;
  logic [3:0]  op_code = 4'h0;
  logic [15:0] op_imm = 16'h0;
  logic        op_ready, stk_push, stk_pop, done, err;
  logic [15:0] stk_din, stk_dout, stk_tos, result;

  localparam logic [3:0] NOP = 4'h0, PUSHI = 4'h1, POP = 4'h2, ADD = 4'h3, SUB = 4'h4,
                         AND_ = 4'h5, OR_ = 4'h6, XOR_ = 4'h7, NOT_ = 4'h8, DUP = 4'h9, MUL = 4'hA;

  stack_exec #(.WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_imm(op_imm), .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_tos(stk_tos), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      stk_tos  <= 16'd0;
      stk_dout <= 16'd0;
    end else if (stk_push && stk_tos < 16'd16) begin
      mem[stk_tos[3:0]] <= stk_din;
      stk_tos <= stk_tos + 16'd1;
    end else if (stk_pop && stk_tos > 16'd0) begin
      stk_dout <= mem[stk_tos[3:0] - 4'd1];
      stk_tos <= stk_tos - 16'd1;
    end
  end

  int both = 0;
  always @(negedge clk) if (stk_push && stk_pop) both++;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] imm,
                        output int lat, output logic e, output int act);
    int w;
    w = 0;
    @(negedge clk);
    while (!op_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!op_ready) chk("ready timeout", 32'd0, 32'd1);
    op_valid = 1'b1; op_code = op; op_imm = imm;
    @(posedge clk);
    #1 op_valid = 1'b0;
    lat = 0; act = 0; e = 1'bx;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      act += int'(stk_push) + int'(stk_pop);
      if (done) begin
        e = err;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] imm;
    int          lat;
    logic        e;
    logic [15:0] res;
    int          tos;
    int          act;
  } vec_t;

  function automatic vec_t mk(logic [3:0] op, logic [15:0] imm, int lat, logic e,
                              logic [15:0] res, int tos, int act);
    vec_t v;
    v.op = op; v.imm = imm; v.lat = lat; v.e = e; v.res = res; v.tos = tos; v.act = act;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int lat, act;
    logic e;

    vecs.push_back(mk(POP,   16'h0,    1, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(NOP,   16'h0,    1, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(PUSHI, 16'h5,    2, 0, 16'h0005, 1, 1));
    vecs.push_back(mk(PUSHI, 16'h3,    2, 0, 16'h0003, 2, 1));
    vecs.push_back(mk(SUB,   16'h0,    5, 0, 16'h0002, 1, 3));
    vecs.push_back(mk(DUP,   16'h0,    5, 0, 16'h0002, 2, 3));
    vecs.push_back(mk(ADD,   16'h0,    5, 0, 16'h0004, 1, 3));
    vecs.push_back(mk(NOT_,  16'h0,    4, 0, 16'hFFFB, 1, 2));
    vecs.push_back(mk(ADD,   16'h0,    1, 1, 16'hFFFB, 1, 0));
    vecs.push_back(mk(4'hF,  16'h0,    1, 1, 16'hFFFB, 1, 0));
    vecs.push_back(mk(PUSHI, 16'hFFFF, 2, 0, 16'hFFFF, 2, 1));
    vecs.push_back(mk(POP,   16'h0,    3, 0, 16'hFFFF, 1, 1));
    vecs.push_back(mk(POP,   16'h0,    3, 0, 16'hFFFB, 0, 1));
    vecs.push_back(mk(PUSHI, 16'hFFFF, 2, 0, 16'hFFFF, 1, 1));
    vecs.push_back(mk(DUP,   16'h0,    5, 0, 16'hFFFF, 2, 3));
    vecs.push_back(mk(ADD,   16'h0,    5, 0, 16'hFFFE, 1, 3));
    vecs.push_back(mk(PUSHI, 16'h00F0, 2, 0, 16'h00F0, 2, 1));
    vecs.push_back(mk(AND_,  16'h0,    5, 0, 16'h00F0, 1, 3));
    vecs.push_back(mk(PUSHI, 16'h0F0F, 2, 0, 16'h0F0F, 2, 1));
    vecs.push_back(mk(OR_,   16'h0,    5, 0, 16'h0FFF, 1, 3));
    vecs.push_back(mk(PUSHI, 16'h00FF, 2, 0, 16'h00FF, 2, 1));
    vecs.push_back(mk(XOR_,  16'h0,    5, 0, 16'h0F00, 1, 3));
    vecs.push_back(mk(SUB,   16'h0,    1, 1, 16'h0F00, 1, 0));
    vecs.push_back(mk(POP,   16'h0,    3, 0, 16'h0F00, 0, 1));
    vecs.push_back(mk(PUSHI, 16'h0012, 2, 0, 16'h0012, 1, 1));
    vecs.push_back(mk(PUSHI, 16'h0034, 2, 0, 16'h0034, 2, 1));
`ifdef STACK_EXEC_MUL_EN
    vecs.push_back(mk(MUL,   16'h0,    5, 0, 16'h03A8, 1, 3));
    vecs.push_back(mk(POP,   16'h0,    3, 0, 16'h03A8, 0, 1));
    vecs.push_back(mk(POP,   16'h0,    1, 1, 16'h03A8, 0, 0));
    vecs.push_back(mk(DUP,   16'h0,    1, 1, 16'h03A8, 0, 0));
`else
    vecs.push_back(mk(MUL,   16'h0,    1, 1, 16'h0034, 2, 0));
    vecs.push_back(mk(POP,   16'h0,    3, 0, 16'h0034, 1, 1));
    vecs.push_back(mk(POP,   16'h0,    3, 0, 16'h0012, 0, 1));
    vecs.push_back(mk(DUP,   16'h0,    1, 1, 16'h0012, 0, 0));
`endif
    vecs.push_back(mk(PUSHI, 16'h0001, 2, 0, 16'h0001, 1, 1));
    vecs.push_back(mk(PUSHI, 16'h0002, 2, 0, 16'h0002, 2, 1));
    vecs.push_back(mk(SUB,   16'h0,    5, 0, 16'hFFFF, 1, 3));
    vecs.push_back(mk(POP,   16'h0,    3, 0, 16'hFFFF, 0, 1));

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst push", stk_push, 0);
    chk("rst pop", stk_pop, 0);
    chk("rst result", result, 0);
    chk("rst din", stk_din, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after rst", op_ready, 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].imm, lat, e, act);
      chk($sformatf("v%0d lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d err", i), e, vecs[i].e);
      chk($sformatf("v%0d result", i), result, vecs[i].res);
      chk($sformatf("v%0d tos", i), stk_tos, vecs[i].tos);
      chk($sformatf("v%0d stack ops", i), act, vecs[i].act);
    end

    // fill to capacity, reject the overflow push and a DUP at full, then drain LIFO
    for (int i = 0; i < 16; i++) begin
      run_op(PUSHI, 16'(i), lat, e, act);
      chk($sformatf("fill%0d err", i), e, 0);
      chk($sformatf("fill%0d tos", i), stk_tos, i + 1);
    end
    run_op(PUSHI, 16'hAAAA, lat, e, act);
    chk("overflow err", e, 1);
    chk("overflow lat", lat, 1);
    chk("overflow tos", stk_tos, 16);
    chk("overflow result", result, 16'd15);
    run_op(DUP, 16'h0, lat, e, act);
    chk("dup full err", e, 1);
    chk("dup full ops", act, 0);
    for (int i = 0; i < 16; i++) begin
      run_op(POP, 16'h0, lat, e, act);
      chk($sformatf("drain%0d result", i), result, 15 - i);
      chk($sformatf("drain%0d tos", i), stk_tos, 15 - i);
    end

    // reset in the middle of a binary op (during CAP_B)
    run_op(PUSHI, 16'h7, lat, e, act);
    run_op(PUSHI, 16'h8, lat, e, act);
    @(negedge clk);
    op_valid = 1'b1; op_code = ADD;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midop in CAP_B (no ctl)", {stk_push, stk_pop, done}, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    chk("midop ready", op_ready, 1);
    chk("midop push", stk_push, 0);
    chk("midop done", done, 0);
    chk("midop tos", stk_tos, 0);
    rst = 1'b0;
    run_op(PUSHI, 16'h0055, lat, e, act);
    chk("post rst lat", lat, 2);
    chk("post rst result", result, 16'h0055);
    chk("post rst tos", stk_tos, 1);

    chk("push/pop overlap", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
